// File: rtl/uart_rx_mmio.sv
// UART receiver with FIFO and memory-mapped read registers (DATA, STATUS).
// Optional even parity (8E1) enabled by defining UART_RX_PARITY_EN.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        rxd_i,
  input  logic        bus_sel_i,
  input  logic        bus_ren_i,
  input  logic [3:0]  bus_addr_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_rvalid_o,
  output logic        irq_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT
  } state_t;

  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [2:0] r_idx, w_nidx;
  logic [7:0] r_shift, w_nshift;
  logic r_rx_meta, r_rx_s;
  logic w_push, w_ferr_set, w_perr_set;
`ifdef UART_RX_PARITY_EN
  logic r_pbad, w_npbad;
`endif

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic r_overrun, r_frame_err, r_par_err;
  logic [31:0] r_rdata, w_rdata;
  logic r_rvalid, r_irq;
  logic w_acc, w_pop, w_full, w_push_ok, w_ovr_set, w_sclr;
  logic [7:0] w_cnt8;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rxd_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_idx   <= w_nidx;
      r_shift <= w_nshift;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_npbad;
`endif
    end
  end

  // Receiver next-state: mid-bit sampling of each frame field
  always_comb begin
    w_nstate   = r_state;
    w_ncnt     = r_cnt + 1'b1;
    w_nidx     = r_idx;
    w_nshift   = r_shift;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_npbad    = r_pbad;
`endif
    case (r_state)
      ST_IDLE: begin
        w_ncnt = '0;
        if (!r_rx_s) w_nstate = ST_START;
      end
      ST_START: begin
        if (r_cnt == C_HALF) begin
          w_ncnt   = '0;
          w_nidx   = '0;
          w_nstate = r_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == C_FULL) begin
          w_ncnt          = '0;
          w_nshift[r_idx] = r_rx_s;
          w_nidx          = r_idx + 1'b1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_nstate = ST_PARITY;
`else
            w_nstate = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == C_FULL) begin
          w_ncnt   = '0;
          w_npbad  = ^{r_shift, r_rx_s};
          w_nstate = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == C_FULL) begin
          w_ncnt = '0;
          if (r_rx_s) begin
            w_push   = 1'b1;
            w_nstate = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_perr_set = r_pbad;
`endif
          end else begin
            w_ferr_set = 1'b1;
            w_nstate   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_ncnt = '0;
        if (r_rx_s) w_nstate = ST_IDLE;
      end
      default: begin
        w_ncnt   = '0;
        w_nstate = ST_IDLE;
      end
    endcase
  end

  assign w_acc     = bus_sel_i & bus_ren_i;
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop     = w_acc && (bus_addr_i == 4'h0) && (r_count != '0);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_sclr    = w_acc && (bus_addr_i == 4'h4);
  assign w_cnt8    = 8'(r_count);

  // FIFO storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  // FIFO pointers, occupancy and sticky status flags
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      r_overrun   <= (r_overrun & ~w_sclr) | w_ovr_set;
      r_frame_err <= (r_frame_err & ~w_sclr) | w_ferr_set;
      r_par_err   <= (r_par_err & ~w_sclr) | w_perr_set;
    end
  end

  // Read-data selection for the accepted offset
  always_comb begin
    w_rdata = '0;
    if (bus_addr_i == 4'h0) begin
      if (r_count != '0) w_rdata = {23'b0, 1'b1, r_mem[r_rptr]};
    end else if (bus_addr_i == 4'h4) begin
      w_rdata = {16'b0, w_cnt8, 4'b0, r_par_err, r_frame_err, r_overrun, w_full};
    end
  end

  // Registered read response and interrupt level
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_acc;
      r_irq    <= (r_count != '0);
      if (w_acc) r_rdata <= w_rdata;
    end
  end

  assign bus_rdata_o  = r_rdata;
  assign bus_rvalid_o = r_rvalid;
  assign irq_o        = r_irq;

endmodule
